mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data/address width.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports i_req_valid (in, 1), i_req_ready (out, 1) and i_req_addr (in, XLEN) for the instruction-fetch request.
REQ-005 SHALL have ports i_resp_valid (out, 1) and i_resp_rdata (out, XLEN) for the fetch response.
REQ-006 SHALL have ports d_req_valid (in, 1), d_req_ready (out, 1), d_req_addr (in, XLEN), d_req_we (in, 1), d_req_wmask (in, XLEN/8) and d_req_wdata (in, XLEN) for the load/store request.
REQ-007 SHALL have ports d_resp_valid (out, 1) and d_resp_rdata (out, XLEN) for the load/store response.
REQ-008 SHALL have ports m_req_valid (out, 1), m_req_ready (in, 1), m_req_addr (out, XLEN), m_req_we (out, 1), m_req_wmask (out, XLEN/8) and m_req_wdata (out, XLEN) for the shared memory request.
REQ-009 SHALL have ports m_resp_valid (in, 1) and m_resp_rdata (in, XLEN) for the shared memory response.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, HOLD and WAIT, plus registers owner (I/D) and last_owner (I/D).
REQ-012 SHALL, in IDLE, select the requester: a single valid requester wins; if both are valid, the one not equal to last_owner wins.
REQ-013 SHALL, in IDLE, drive m_req_valid = i_req_valid | d_req_valid combinationally, with the selected requester's fields on m_req_*.
REQ-014 SHALL drive the selected requester's ready = m_req_ready and hold the other requester's ready at 0.
REQ-015 SHALL, on an IDLE handshake (m_req_valid & m_req_ready), latch owner = selected and go to WAIT.
REQ-016 SHALL, in IDLE with m_req_valid & !m_req_ready, latch owner = selected and go to HOLD.
REQ-017 SHALL, in HOLD, drive m_req_valid and m_req_* from owner's inputs only; the selection is locked and a newly valid other requester is ignored.
REQ-018 SHALL, in HOLD, move to WAIT on m_req_ready.
REQ-019 SHALL, in HOLD, return to IDLE if the owner drops valid (protocol tolerance, no transaction).
REQ-020 SHALL, in WAIT, drive m_req_valid = 0 and both readys = 0.
REQ-021 SHALL, in WAIT, on m_resp_valid: pulse owner's resp_valid for exactly that cycle (zero added latency), set last_owner = owner and go to IDLE.
REQ-022 SHALL issue the next request no earlier than the cycle after the response (one transaction outstanding maximum).
REQ-023 SHALL drive i_resp_rdata and d_resp_rdata as pass-throughs of m_resp_rdata; the non-owner's resp_valid is always 0.
REQ-024 SHALL force m_req_we = 0, m_req_wmask = 0 and m_req_wdata = 0 for fetches.
REQ-025 SHALL force all m_req_* fields to 0 when m_req_valid = 0.
REQ-026 SHALL pulse d_resp_valid for stores as well; rdata is then don't-care.
REQ-027 SHALL ignore m_resp_valid in IDLE or HOLD: no resp_valid pulse and no state change.

Reset
REQ-028 SHALL, while reset = 0, force state = IDLE, owner = I, last_owner = D, all resp_valid = 0 and busy = 0, with outputs following IDLE rules.
REQ-029 SHALL abandon any in-flight transaction on reset assertion mid-HOLD or mid-WAIT; a late m_resp_valid after release produces no response.
REQ-030 SHALL grant I on the first simultaneous request after reset, because last_owner = D.

Verification
REQ-031 SHALL cover: fetch only, i_req_addr = 0x100, m_req_ready = 1, m_resp_valid two cycles later with 0x00500093 -> i_resp_valid one cycle with 0x00500093, d_resp_valid = 0, busy high for two cycles.
REQ-032 SHALL cover: after reset, both valid (I 0x100, D 0x2000) -> m_req_addr order 0x100 then 0x2000; next simultaneous tie goes to I again.
REQ-033 SHALL cover: I selected, m_req_ready low three cycles, d_req_valid rises during HOLD -> m_req_addr stable at 0x100, d_req_ready = 0 throughout, D served afterwards.
REQ-034 SHALL cover: store d_req_we = 1, wmask = 0b0011, wdata = 0xDEADBEEF, addr 0x40 -> identical values on m_req_*, single d_resp_valid pulse.
REQ-035 SHALL cover: reset asserted in WAIT, m_resp_valid arriving after release -> no resp_valid pulse, busy = 0.
REQ-036 SHALL cover: m_resp_valid in IDLE with no request -> no response and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one memory port.
// One transaction outstanding; ties alternate away from the last served requester.
module mem_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [XLEN-1:0]   i_req_addr,
  output logic              i_resp_valid,
  output logic [XLEN-1:0]   i_resp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_we,
  input  logic [XLEN/8-1:0] d_req_wmask,
  input  logic [XLEN-1:0]   d_req_wdata,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [XLEN-1:0]   m_req_addr,
  output logic              m_req_we,
  output logic [XLEN/8-1:0] m_req_wmask,
  output logic [XLEN-1:0]   m_req_wdata,
  input  logic              m_resp_valid,
  input  logic [XLEN-1:0]   m_resp_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_e;
  typedef enum logic       {OWN_I, OWN_D}     owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  owner_e sel;
  logic   req_v;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    sel          = owner_q;
    req_v        = 1'b0;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_we     = 1'b0;
    m_req_wmask  = '0;
    m_req_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req_valid && d_req_valid) sel = (last_q == OWN_I) ? OWN_D : OWN_I;
        else if (d_req_valid)           sel = OWN_D;
        else                            sel = OWN_I;
        req_v = i_req_valid | d_req_valid;
        if (req_v) begin
          owner_d = sel;
          state_d = m_req_ready ? WAIT : HOLD;
        end
      end
      HOLD: begin
        // Selection is locked to the owner; the other side is ignored here.
        sel   = owner_q;
        req_v = (owner_q == OWN_I) ? i_req_valid : d_req_valid;
        if (!req_v)           state_d = IDLE;
        else if (m_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (m_resp_valid) begin
          i_resp_valid = (owner_q == OWN_I);
          d_resp_valid = (owner_q == OWN_D);
          last_d       = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != WAIT) begin
      i_req_ready = (sel == OWN_I) && m_req_ready;
      d_req_ready = (sel == OWN_D) && m_req_ready;
    end

    m_req_valid = req_v;
    if (req_v) begin
      if (sel == OWN_D) begin
        m_req_addr  = d_req_addr;
        m_req_we    = d_req_we;
        m_req_wmask = d_req_wmask;
        m_req_wdata = d_req_wdata;
      end else begin
        m_req_addr  = i_req_addr;
      end
    end
  end

  assign i_resp_rdata = m_resp_rdata;
  assign d_resp_rdata = m_resp_rdata;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            i_req_valid, i_req_ready;
  logic [XLEN-1:0] i_req_addr;
  logic            i_resp_valid;
  logic [XLEN-1:0] i_resp_rdata;
  logic            d_req_valid, d_req_ready;
  logic [XLEN-1:0] d_req_addr;
  logic            d_req_we;
  logic [3:0]      d_req_wmask;
  logic [XLEN-1:0] d_req_wdata;
  logic            d_resp_valid;
  logic [XLEN-1:0] d_resp_rdata;
  logic            m_req_valid, m_req_ready;
  logic [XLEN-1:0] m_req_addr;
  logic            m_req_we;
  logic [3:0]      m_req_wmask;
  logic [XLEN-1:0] m_req_wdata;
  logic            m_resp_valid;
  logic [XLEN-1:0] m_resp_rdata;
  logic            busy;

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wmask(d_req_wmask), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wmask(m_req_wmask), .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [31:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] m, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.mask = m; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_resp(input logic is_d, input logic chk_data, input logic [31:0] d);
    resp_t r;
    r.is_d = is_d; r.chk_data = chk_data; r.data = d;
    resp_q.push_back(r);
  endtask

  // Monitor: every memory handshake and every response must match the head of its queue.
  always @(negedge clock) begin
    if (m_req_valid && m_req_ready) begin
      if (req_q.size() == 0) begin
        chk("unexpected_m_req", {31'd0, m_req_valid}, 32'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        chk("m_req_addr", m_req_addr, r.addr);
        chk("m_req_we", {31'd0, m_req_we}, {31'd0, r.we});
        chk("m_req_wmask", {28'd0, m_req_wmask}, {28'd0, r.mask});
        chk("m_req_wdata", m_req_wdata, r.wdata);
      end
    end
    if (i_resp_valid || d_resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_port", {30'd0, i_resp_valid, d_resp_valid}, r.is_d ? 32'd1 : 32'd2);
        if (r.chk_data)
          chk("resp_rdata", r.is_d ? d_resp_rdata : i_resp_rdata, r.data);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic respond(input logic [31:0] d);
    m_resp_valid = 1'b1;
    m_resp_rdata = d;
    tick();
    m_resp_valid = 1'b0;
    m_resp_rdata = 32'h0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_req_valid = 1'b0; i_req_addr = 32'h0000_0AAC;
    d_req_valid = 1'b0; d_req_addr = 32'h0000_5555;
    d_req_we = 1'b1; d_req_wmask = 4'hF; d_req_wdata = 32'hCAFE_F00D;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = 32'h0;

    // Reset state: idle, nothing on the memory port despite junk inputs.
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_valid", {31'd0, m_req_valid}, 32'd0);
    chk("rst_m_addr", m_req_addr, 32'd0);
    chk("rst_m_wdata", m_req_wdata, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Fetch only; D-side store fields are live but must not leak onto a fetch.
    i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
    exp_req(32'h100, 1'b0, 4'h0, 32'h0);
    exp_resp(1'b0, 1'b1, 32'h0050_0093);
    @(negedge clock);
    chk("f_i_ready", {31'd0, i_req_ready}, 32'd1);
    chk("f_d_ready", {31'd0, d_req_ready}, 32'd0);
    tick();
    i_req_valid = 1'b0; m_req_ready = 1'b0;
    @(negedge clock);
    chk("f_busy0", {31'd0, busy}, 32'd1);
    chk("f_wait_mvalid", {31'd0, m_req_valid}, 32'd0);
    tick();
    m_resp_valid = 1'b1; m_resp_rdata = 32'h0050_0093;
    @(negedge clock);
    chk("f_busy1", {31'd0, busy}, 32'd1);
    tick();
    m_resp_valid = 1'b0;
    @(negedge clock);
    chk("f_busy_done", {31'd0, busy}, 32'd0);

    // Tie after reset goes to I, then D, then I again on the next tie.
    do_reset();
    d_req_we = 1'b0; d_req_wmask = 4'h0; d_req_wdata = 32'h0;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_addr = 32'h2000;
    m_req_ready = 1'b1;
    exp_req(32'h100, 1'b0, 4'h0, 32'h0);
    exp_resp(1'b0, 1'b1, 32'h11);
    @(negedge clock);
    chk("tie_i_ready", {31'd0, i_req_ready}, 32'd1);
    chk("tie_d_ready", {31'd0, d_req_ready}, 32'd0);
    tick();
    i_req_valid = 1'b0;
    @(negedge clock);
    chk("tie_wait_d_ready", {31'd0, d_req_ready}, 32'd0);
    exp_req(32'h2000, 1'b0, 4'h0, 32'h0);
    respond(32'h11);
    exp_resp(1'b1, 1'b1, 32'h22);
    tick();
    d_req_valid = 1'b0;
    respond(32'h22);
    i_req_valid = 1'b1; i_req_addr = 32'h104;
    d_req_valid = 1'b1; d_req_addr = 32'h2004;
    exp_req(32'h104, 1'b0, 4'h0, 32'h0);
    exp_resp(1'b0, 1'b1, 32'h33);
    tick();
    i_req_valid = 1'b0;
    exp_req(32'h2004, 1'b0, 4'h0, 32'h0);
    respond(32'h33);
    exp_resp(1'b1, 1'b1, 32'h44);
    tick();
    d_req_valid = 1'b0;
    respond(32'h44);

    // HOLD lock: I stalled three cycles, D arrives mid-stall and must wait.
    m_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("hold_addr", m_req_addr, 32'h100);
      chk("hold_d_ready", {31'd0, d_req_ready}, 32'd0);
      chk("hold_mvalid", {31'd0, m_req_valid}, 32'd1);
      tick();
      d_req_valid = 1'b1; d_req_addr = 32'h3000;
    end
    m_req_ready = 1'b1;
    exp_req(32'h100, 1'b0, 4'h0, 32'h0);
    exp_resp(1'b0, 1'b1, 32'h55);
    @(negedge clock);
    chk("hold_rel_d_ready", {31'd0, d_req_ready}, 32'd0);
    tick();
    i_req_valid = 1'b0;
    exp_req(32'h3000, 1'b0, 4'h0, 32'h0);
    respond(32'h55);
    exp_resp(1'b1, 1'b1, 32'h66);
    tick();
    d_req_valid = 1'b0;
    respond(32'h66);

    // Store passes through unchanged; one d_resp pulse, data don't-care.
    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b1;
    d_req_wmask = 4'b0011; d_req_wdata = 32'hDEAD_BEEF;
    exp_req(32'h40, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    exp_resp(1'b1, 1'b0, 32'h0);
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wmask = 4'h0; d_req_wdata = 32'h0;
    respond(32'h0BAD_0BAD);
    @(negedge clock);
    chk("st_after_busy", {31'd0, busy}, 32'd0);

    // Owner drops valid in HOLD: back to IDLE, no transaction.
    m_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h180;
    tick();
    i_req_valid = 1'b0;
    @(negedge clock);
    chk("drop_mvalid", {31'd0, m_req_valid}, 32'd0);
    chk("drop_busy_hold", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clock);
    chk("drop_busy_idle", {31'd0, busy}, 32'd0);

    // Reset mid-WAIT; a late response afterwards produces nothing.
    i_req_valid = 1'b1; i_req_addr = 32'h200; m_req_ready = 1'b1;
    exp_req(32'h200, 1'b0, 4'h0, 32'h0);
    tick();
    i_req_valid = 1'b0; m_req_ready = 1'b0;
    @(negedge clock);
    chk("rw_busy_wait", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rw_busy_rst", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    m_resp_valid = 1'b1; m_resp_rdata = 32'h7777;
    @(negedge clock);
    chk("rw_late_busy", {31'd0, busy}, 32'd0);
    tick();
    m_resp_valid = 1'b0;

    // Stray response in IDLE with no request.
    m_resp_valid = 1'b1; m_resp_rdata = 32'h8888;
    @(negedge clock);
    chk("stray_mvalid", {31'd0, m_req_valid}, 32'd0);
    tick();
    m_resp_valid = 1'b0;
    @(negedge clock);
    chk("stray_busy", {31'd0, busy}, 32'd0);

    tick();
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
